kamikaze_fetch_aligner: RTL and testbench
=========================================

KAMIKAZE_FETCH_ALIGNER -- requirements
Module: kamikaze_fetch_aligner

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC of the first instruction after reset.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1: redirect request (branch/jump/trap).
REQ-005 SHALL have port flush_pc_i, input, 32: redirect target; bit 0 ignored.
REQ-006 SHALL have port fetch_valid_i, input, 1: fetch word available.
REQ-007 SHALL have port fetch_rdata_i, input, 32: word-aligned fetch data; little-endian halfwords.
REQ-008 SHALL have port fetch_ready_o, output, 1: word accepted when fetch_valid_i && fetch_ready_o.
REQ-009 SHALL have port instr_valid_o, output, 1: instruction presented to the compressed decoder.
REQ-010 SHALL have port instr_o, output, 32: raw instruction; compressed forms zero-extended as {16'h0000, hw}.
REQ-011 SHALL have port instr_pc_o, output, 32: halfword-aligned PC of instr_o.
REQ-012 SHALL have port instr_compressed_o, output, 1: 1 when instr_o[1:0] != 2'b11.
REQ-013 SHALL have port instr_ready_i, input, 1: instruction consumed when instr_valid_o && instr_ready_i.

Function
REQ-014 SHALL hold a 32-bit word buffer buf_q, a PC register pc_q and a state register with states EMPTY, WORD (pc_q[1]=0, both halves pending) and HALF (pc_q[1]=1, upper half pending).
REQ-015 SHALL drive instr_o, instr_valid_o, instr_compressed_o and fetch_ready_o combinationally from the state, buf_q and the fetch inputs; instr_pc_o SHALL equal pc_q.
REQ-016 EMPTY: instr_valid_o=0, fetch_ready_o=1; on accept, load buf_q and go to WORD if pc_q[1]=0, else HALF (lower halfword discarded).
REQ-017 WORD, buf_q[1:0]!=2'b11: present {16'h0, buf_q[15:0]}, compressed; on consume, pc_q+=2 and go to HALF; fetch_ready_o=0.
REQ-018 WORD, buf_q[1:0]==2'b11: present buf_q, uncompressed; fetch_ready_o=instr_ready_i; on consume, pc_q+=4 and go to WORD if a word is accepted in the same cycle, else EMPTY.
REQ-019 HALF, buf_q[17:16]!=2'b11: present {16'h0, buf_q[31:16]}, compressed; fetch_ready_o=instr_ready_i; on consume, pc_q+=2 and go to WORD if a word is accepted in the same cycle, else EMPTY.
REQ-020 HALF, buf_q[17:16]==2'b11 (straddling): instr_valid_o=fetch_valid_i; instr_o={fetch_rdata_i[15:0], buf_q[31:16]}; fetch_ready_o=instr_ready_i; on consume, load the fetched word, pc_q+=4, stay in HALF.
REQ-021 A word SHALL never be accepted without a buffer slot; an accepted word SHALL never be dropped except by flush.
REQ-022 Holding rule: while instr_valid_o=1 and instr_ready_i=0, instr_o, instr_pc_o and instr_compressed_o SHALL remain stable unless flush_i=1.
REQ-023 flush_i SHALL take priority over every other event: in the flush cycle instr_valid_o=0, fetch_ready_o=0, no accept or consume; next state EMPTY, pc_q=flush_pc_i with bit 0 cleared, buffer discarded.
REQ-024 PC arithmetic SHALL be modulo 2^32 (wrap 32'hFFFF_FFFE+2 = 32'h0).
REQ-025 Latency: a fetched word accepted in EMPTY SHALL produce instr_valid_o in the next cycle; back-to-back uncompressed or straddling instructions SHALL sustain one per cycle.

Reset
REQ-026 While rst_i=1: state EMPTY, pc_q=RESET_PC, buf_q=0, instr_valid_o=0, fetch_ready_o=0; operation starts on the first clock edge after deassertion.
REQ-027 Reset asserted mid-straddle SHALL discard the buffered halfword with no instruction issued.

Verification
REQ-028 Reset, then words 32'h00A0_0093, 32'h0010_0113 with ready held high -> instr_o 32'h00A0_0093 @PC 0, 32'h0010_0113 @PC 4, compressed=0, one per cycle.
REQ-029 Word 32'h0093_4505 -> {16'h0,16'h4505} @PC 0 compressed=1; then straddle with next word 32'h1234_00A0 -> instr_o 32'h00A0_0093 @PC 2 compressed=0.
REQ-030 Word 32'h4585_4505 -> two compressed instructions @PC 0 and @PC 2; fetch_ready_o=0 during the first.
REQ-031 flush_i with flush_pc_i=32'h0000_0102 while instr_valid_o=1 -> no consume that cycle; next word 32'h4611_0001 -> first output {16'h0,16'h4611} @PC 32'h102.
REQ-032 instr_ready_i=0 for 3 cycles on a valid instruction -> outputs stable, fetch_ready_o=0, no word lost.
REQ-033 pc_q=32'hFFFF_FFFC, uncompressed word consumed -> instr_pc_o wraps to 32'h0000_0000.

Source files
------------

// File: rtl/kamikaze_fetch_aligner.sv
// Fetch aligner: splits word-aligned fetch data into 16/32-bit RISC-V instructions,
// reassembling 32-bit instructions that straddle two fetch words.
module kamikaze_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    input  logic        instr_ready_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WORD  = 2'd1,
        HALF  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] buf_reg;

    logic word_compressed;
    logic half_compressed;
    logic consume;
    logic accept;

    assign word_compressed = (buf_reg[1:0] != 2'b11);
    assign half_compressed = (buf_reg[17:16] != 2'b11);

    always_comb begin
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = buf_reg;
        case (state_reg)
            EMPTY: begin
                fetch_ready_o = 1'b1;
            end
            WORD: begin
                instr_valid_o = 1'b1;
                if (word_compressed) begin
                    instr_o = {16'h0000, buf_reg[15:0]};
                end else begin
                    instr_o       = buf_reg;
                    fetch_ready_o = instr_ready_i;
                end
            end
            HALF: begin
                fetch_ready_o = instr_ready_i;
                if (half_compressed) begin
                    instr_valid_o = 1'b1;
                    instr_o       = {16'h0000, buf_reg[31:16]};
                end else begin
                    // Straddling: the upper half comes straight from the incoming word.
                    instr_valid_o = fetch_valid_i;
                    instr_o       = {fetch_rdata_i[15:0], buf_reg[31:16]};
                end
            end
            default: begin
                instr_valid_o = 1'b0;
            end
        endcase
        if (flush_i || rst_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    assign instr_compressed_o = (instr_o[1:0] != 2'b11);
    assign instr_pc_o         = pc_reg;
    assign consume            = instr_valid_o && instr_ready_i;
    assign accept             = fetch_valid_i && fetch_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            pc_reg    <= RESET_PC;
            buf_reg   <= 32'h0000_0000;
        end else if (flush_i) begin
            state_reg <= EMPTY;
            pc_reg    <= {flush_pc_i[31:1], 1'b0};
            buf_reg   <= 32'h0000_0000;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        buf_reg   <= fetch_rdata_i;
                        state_reg <= pc_reg[1] ? HALF : WORD;
                    end
                end
                WORD: begin
                    if (consume) begin
                        if (word_compressed) begin
                            pc_reg    <= pc_reg + 32'd2;
                            state_reg <= HALF;
                        end else begin
                            pc_reg <= pc_reg + 32'd4;
                            if (accept) begin
                                buf_reg   <= fetch_rdata_i;
                                state_reg <= WORD;
                            end else begin
                                state_reg <= EMPTY;
                            end
                        end
                    end
                end
                HALF: begin
                    if (consume) begin
                        if (half_compressed) begin
                            pc_reg <= pc_reg + 32'd2;
                            if (accept) begin
                                buf_reg   <= fetch_rdata_i;
                                state_reg <= WORD;
                            end else begin
                                state_reg <= EMPTY;
                            end
                        end else begin
                            buf_reg   <= fetch_rdata_i;
                            pc_reg    <= pc_reg + 32'd4;
                            state_reg <= HALF;
                        end
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kamikaze_fetch_aligner.sv
// Directed bench for kamikaze_fetch_aligner: hand-computed vectors per scenario.
module tb_kamikaze_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;
    logic        instr_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Full view: {valid, fetch_ready, compressed, pc, instr}; short view: {valid, fetch_ready, pc}
    logic [66:0] obs, exp;
    logic [33:0] sobs, sexp;

    kamikaze_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .flush_pc_i        (flush_pc),
        .fetch_valid_i     (fetch_valid),
        .fetch_rdata_i     (fetch_rdata),
        .fetch_ready_o     (fetch_ready_o),
        .instr_valid_o     (instr_valid_o),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .instr_compressed_o(instr_compressed_o),
        .instr_ready_i     (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; fetch_valid = 1'b0;
        fetch_rdata = 32'h0; instr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL reset_release: got %h expected %h", sobs, sexp); end
        flush = 1'b1; flush_pc = 32'h0000_0040;
        tick();
        flush = 1'b0; fetch_valid = 1'b1; fetch_rdata = 32'h00A0_0093;
        tick();
        fetch_valid = 1'b0;
        rst = 1'b1;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b0, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL reset_async: got %h expected %h", sobs, sexp); end
        fetch_valid = 1'b1;
        tick();
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b0, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL reset_held: got %h expected %h", sobs, sexp); end
        rst = 1'b0; fetch_valid = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h00A0_0093;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL b2b_empty: got %h expected %h", sobs, sexp); end
        tick();
        fetch_rdata = 32'h0010_0113;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h00A0_0093};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL b2b_first: got %h expected %h", obs, exp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h0010_0113};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL b2b_second: got %h expected %h", obs, exp); end
        tick();
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h8};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL b2b_drained: got %h expected %h", sobs, sexp); end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_straddle();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h0093_4505;
        tick();
        fetch_rdata = 32'h1234_00A0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_4505};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL straddle_c0: got %h expected %h", obs, exp); end
        tick();
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b0, 32'h2, 32'h00A0_0093};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL straddle_join: got %h expected %h", obs, exp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b1, 32'h6, 32'h0000_1234};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL straddle_tail: got %h expected %h", obs, exp); end
        tick();
        $display("[TB] test_straddle done");
    endtask

    task automatic test_two_compressed();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h4585_4505;
        tick();
        fetch_rdata = 32'hDEAD_BEEF;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_4505};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL twoc_first: got %h expected %h", obs, exp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b1, 32'h2, 32'h0000_4585};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL twoc_second: got %h expected %h", obs, exp); end
        tick();
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h4};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL twoc_drained: got %h expected %h", sobs, sexp); end
        $display("[TB] test_two_compressed done");
    endtask

    task automatic test_flush();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h00A0_0093;
        tick();
        flush = 1'b1; flush_pc = 32'h0000_0102; fetch_rdata = 32'h0010_0113;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b0, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL flush_cycle: got %h expected %h", sobs, sexp); end
        tick();
        flush = 1'b0; fetch_rdata = 32'h4611_0001;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h102};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL flush_target: got %h expected %h", sobs, sexp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b1, 32'h102, 32'h0000_4611};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL flush_first_instr: got %h expected %h", obs, exp); end
        tick();
        $display("[TB] test_flush done");
    endtask

    task automatic test_stall();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h00A0_0093;
        tick();
        instr_ready = 1'b0; fetch_rdata = 32'h0010_0113;
        for (int i = 0; i < 3; i++) begin
            #1;
            obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
            exp = {1'b1, 1'b0, 1'b0, 32'h0, 32'h00A0_0093};
            tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h0010_0113};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL stall_no_loss: got %h expected %h", obs, exp); end
        tick();
        $display("[TB] test_stall done");
    endtask

    task automatic test_reset_mid_straddle();
        do_reset();
        fetch_valid = 1'b1; fetch_rdata = 32'h0093_4505;
        tick();
        fetch_valid = 1'b0;
        tick();
        fetch_valid = 1'b1; fetch_rdata = 32'h1234_00A0; instr_ready = 1'b0;
        rst = 1'b1;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b0, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL rst_straddle_kill: got %h expected %h", sobs, sexp); end
        tick();
        rst = 1'b0; instr_ready = 1'b1; fetch_rdata = 32'h4505_4505;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL rst_straddle_empty: got %h expected %h", sobs, sexp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_4505};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL rst_straddle_fresh: got %h expected %h", obs, exp); end
        $display("[TB] test_reset_mid_straddle done");
    endtask

    task automatic test_pc_wrap();
        do_reset();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0; fetch_valid = 1'b1; fetch_rdata = 32'h00A0_0093;
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h00A0_0093};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL wrap_word_at_top: got %h expected %h", obs, exp); end
        tick();
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL wrap_word_pc: got %h expected %h", sobs, sexp); end
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0; fetch_valid = 1'b1; fetch_rdata = 32'h4505_0000;
        #1;
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'hFFFF_FFFE};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL wrap_flush_bit0: got %h expected %h", sobs, sexp); end
        tick();
        fetch_valid = 1'b0;
        #1;
        obs = {instr_valid_o, fetch_ready_o, instr_compressed_o, instr_pc_o, instr_o};
        exp = {1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_4505};
        tests_run++; if (obs !== exp) begin tests_failed++; $display("FAIL wrap_half_at_top: got %h expected %h", obs, exp); end
        tick();
        sobs = {instr_valid_o, fetch_ready_o, instr_pc_o}; sexp = {1'b0, 1'b1, 32'h0};
        tests_run++; if (sobs !== sexp) begin tests_failed++; $display("FAIL wrap_half_pc: got %h expected %h", sobs, sexp); end
        $display("[TB] test_pc_wrap done");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; fetch_valid = 1'b0;
        fetch_rdata = 32'h0; instr_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_straddle();
        test_two_compressed();
        test_flush();
        test_stall();
        test_reset_mid_straddle();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
